axi_rd_arbiter: RTL and testbench

- Shares one AXI4 read address/data channel pair between two cache masters.
- Port 0 is i_cache; port 1 is d_cache or the uncached load path.
- Allows one outstanding burst at a time. Picks a master by round-robin or fixed priority, registers its AR fields, then routes R beats back only to the granted master.
- Sits between both caches and the core's AXI bridge. It also checks that burst length matches the rlast beat.

---
 rtl/axi_rd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: one outstanding burst, round-robin or fixed priority (port 1 wins).
// Latency: AR registered (arvalid to s_arvalid is 1 cycle); R path is combinational to the granted master.
module axi_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           m0_araddr,
  input  logic [7:0]            m0_arlen,
  input  logic [1:0]            m0_arburst,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  output logic                  m0_rlast,
  input  logic                  m0_rready,
  input  logic [31:0]           m1_araddr,
  input  logic [7:0]            m1_arlen,
  input  logic [1:0]            m1_arburst,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic                  m1_rlast,
  input  logic                  m1_rready,
  output logic [31:0]           s_araddr,
  output logic [7:0]            s_arlen,
  output logic [1:0]            s_arburst,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_rvalid,
  input  logic                  s_rlast,
  output logic                  s_rready,
  output logic                  beat_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [1:0]  arburst_q, arburst_d;
  logic        arvalid_q, arvalid_d;
  logic        beat_err_q, beat_err_d;

  logic req_any;
  logic win;
  logic beat_done;

  assign req_any   = m0_arvalid | m1_arvalid;
  assign beat_done = (state_q == DATA) && s_rvalid && s_rready;

  // Tie-break: round-robin flips away from the last winner, fixed mode always favours port 1.
  always_comb begin
    win = m1_arvalid;
    if (m0_arvalid && m1_arvalid) begin
      win = (ARB_MODE == 1) ? 1'b1 : ~last_grant_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = ADDR;
      ADDR:    if (s_arready) state_d = DATA;
      DATA:    if (beat_done && s_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arburst_d    = arburst_q;
    arvalid_d    = arvalid_q;
    beat_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d      = win;
          last_grant_d = win;
          araddr_d     = win ? m1_araddr  : m0_araddr;
          arlen_d      = win ? m1_arlen   : m0_arlen;
          arburst_d    = win ? m1_arburst : m0_arburst;
          arvalid_d    = 1'b1;
        end
      end
      ADDR: begin
        if (s_arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = 8'd0;
        end
      end
      DATA: begin
        if (beat_done) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // beat_cnt still holds the index of the beat carrying rlast.
          if (s_rlast) beat_err_d = (beat_cnt_q != arlen_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= 8'd0;
      araddr_q     <= 32'd0;
      arlen_q      <= 8'd0;
      arburst_q    <= 2'd0;
      arvalid_q    <= 1'b0;
      beat_err_q   <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arburst_q    <= arburst_d;
      arvalid_q    <= arvalid_d;
      beat_err_q   <= beat_err_d;
    end
  end

  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rlast   = 1'b0;
    m1_rlast   = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    s_rready   = 1'b0;
    case (state_q)
      ADDR: begin
        if (grant_q) m1_arready = s_arready;
        else         m0_arready = s_arready;
      end
      DATA: begin
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rlast  = s_rlast;
          m1_rdata  = s_rdata;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rlast  = s_rlast;
          m0_rdata  = s_rdata;
          s_rready  = m0_rready;
        end
      end
      default: ;
    endcase
  end

  assign s_araddr  = araddr_q;
  assign s_arlen   = arlen_q;
  assign s_arburst = arburst_q;
  assign s_arvalid = arvalid_q;
  assign beat_err  = beat_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: two instances (round-robin and fixed priority) checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_axi_rd_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // index [d] selects the instance (d == ARB_MODE), [n] the master port
  logic [31:0]   araddr[2][2];
  logic [7:0]    arlen[2][2];
  logic [1:0]    arburst[2][2];
  logic          arvalid[2][2];
  logic          rready[2][2];
  logic          arready[2][2];
  logic [DW-1:0] rdata[2][2];
  logic          rvalid[2][2];
  logic          rlast[2][2];
  logic [31:0]   s_araddr[2];
  logic [7:0]    s_arlen[2];
  logic [1:0]    s_arburst[2];
  logic          s_arvalid[2];
  logic          s_arready[2];
  logic [DW-1:0] s_rdata[2];
  logic          s_rvalid[2];
  logic          s_rlast[2];
  logic          s_rready[2];
  logic          beat_err[2];
  logic          busy[2];

  axi_rd_arbiter #(.DATA_WIDTH(DW), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst_n),
    .m0_araddr(araddr[0][0]), .m0_arlen(arlen[0][0]), .m0_arburst(arburst[0][0]),
    .m0_arvalid(arvalid[0][0]), .m0_arready(arready[0][0]), .m0_rdata(rdata[0][0]),
    .m0_rvalid(rvalid[0][0]), .m0_rlast(rlast[0][0]), .m0_rready(rready[0][0]),
    .m1_araddr(araddr[0][1]), .m1_arlen(arlen[0][1]), .m1_arburst(arburst[0][1]),
    .m1_arvalid(arvalid[0][1]), .m1_arready(arready[0][1]), .m1_rdata(rdata[0][1]),
    .m1_rvalid(rvalid[0][1]), .m1_rlast(rlast[0][1]), .m1_rready(rready[0][1]),
    .s_araddr(s_araddr[0]), .s_arlen(s_arlen[0]), .s_arburst(s_arburst[0]),
    .s_arvalid(s_arvalid[0]), .s_arready(s_arready[0]), .s_rdata(s_rdata[0]),
    .s_rvalid(s_rvalid[0]), .s_rlast(s_rlast[0]), .s_rready(s_rready[0]),
    .beat_err(beat_err[0]), .busy(busy[0])
  );

  axi_rd_arbiter #(.DATA_WIDTH(DW), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst_n),
    .m0_araddr(araddr[1][0]), .m0_arlen(arlen[1][0]), .m0_arburst(arburst[1][0]),
    .m0_arvalid(arvalid[1][0]), .m0_arready(arready[1][0]), .m0_rdata(rdata[1][0]),
    .m0_rvalid(rvalid[1][0]), .m0_rlast(rlast[1][0]), .m0_rready(rready[1][0]),
    .m1_araddr(araddr[1][1]), .m1_arlen(arlen[1][1]), .m1_arburst(arburst[1][1]),
    .m1_arvalid(arvalid[1][1]), .m1_arready(arready[1][1]), .m1_rdata(rdata[1][1]),
    .m1_rvalid(rvalid[1][1]), .m1_rlast(rlast[1][1]), .m1_rready(rready[1][1]),
    .s_araddr(s_araddr[1]), .s_arlen(s_arlen[1]), .s_arburst(s_arburst[1]),
    .s_arvalid(s_arvalid[1]), .s_arready(s_arready[1]), .s_rdata(s_rdata[1]),
    .s_rvalid(s_rvalid[1]), .s_rlast(s_rlast[1]), .s_rready(s_rready[1]),
    .beat_err(beat_err[1]), .busy(busy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the single in-flight transaction as a record
  bit          t_act[2];
  bit          t_acc[2];
  int          t_own[2];
  int          t_beats[2];
  logic [31:0] l_addr[2];
  logic [7:0]  l_len[2];
  logic [1:0]  l_burst[2];
  int          last_win[2];
  bit          err_exp[2];

  // Observations and agent state
  int          obs_grants[2][$];
  logic [31:0] rx[2][2][$];
  bit          rxl[2][2][$];
  int          rv_seen[2][2];
  int          arrdy_seen[2][2];
  int          err_cnt[2];
  bit          ar_hs[2][2];
  int          bq[2][$];
  int          bidx[2];
  bit          auto_en[2];
  int          p_req, p_rdy, p_ar, p_rv, p_err;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset(int d);
    t_act[d] = 0; t_acc[d] = 0; t_own[d] = 0; t_beats[d] = 0;
    l_addr[d] = '0; l_len[d] = '0; l_burst[d] = '0;
    last_win[d] = 1; err_exp[d] = 0;
  endfunction

  function automatic void model_step(int d);
    bit e;
    int w;
    e = 0;
    if (!t_act[d]) begin
      if (arvalid[d][0] || arvalid[d][1]) begin
        if (arvalid[d][0] && arvalid[d][1]) w = (d == 1) ? 1 : 1 - last_win[d];
        else                                w = arvalid[d][1] ? 1 : 0;
        t_act[d] = 1; t_acc[d] = 0; t_own[d] = w; t_beats[d] = 0; last_win[d] = w;
        l_addr[d] = araddr[d][w]; l_len[d] = arlen[d][w]; l_burst[d] = arburst[d][w];
      end
    end else if (!t_acc[d]) begin
      if (s_arready[d]) t_acc[d] = 1;
    end else if (s_rvalid[d] && rready[d][t_own[d]]) begin
      if (s_rlast[d]) begin
        e = ((t_beats[d] % 256) != int'(l_len[d]));
        t_act[d] = 0;
      end
      t_beats[d]++;
    end
    err_exp[d] = e;
  endfunction

  task automatic check(int d);
    bit dat;
    string p;
    dat = t_act[d] && t_acc[d];
    p = $sformatf("d%0d ", d);
    chk({p, "busy"},      busy[d],      t_act[d]);
    chk({p, "s_arvalid"}, s_arvalid[d], t_act[d] && !t_acc[d]);
    chk({p, "s_araddr"},  s_araddr[d],  l_addr[d]);
    chk({p, "s_arlen"},   s_arlen[d],   l_len[d]);
    chk({p, "s_arburst"}, s_arburst[d], l_burst[d]);
    chk({p, "beat_err"},  beat_err[d],  err_exp[d]);
    chk({p, "s_rready"},  s_rready[d],  dat ? rready[d][t_own[d]] : 1'b0);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("d%0d m%0d_arready", d, n), arready[d][n],
          t_act[d] && !t_acc[d] && t_own[d] == n && s_arready[d]);
      chk($sformatf("d%0d m%0d_rvalid", d, n), rvalid[d][n], dat && t_own[d] == n && s_rvalid[d]);
      chk($sformatf("d%0d m%0d_rlast", d, n),  rlast[d][n],  dat && t_own[d] == n && s_rlast[d]);
      chk($sformatf("d%0d m%0d_rdata", d, n),  rdata[d][n],
          (dat && t_own[d] == n) ? s_rdata[d] : '0);
    end
  endtask

  task automatic observe(int d);
    int pl;
    for (int n = 0; n < 2; n++) begin
      ar_hs[d][n] = arvalid[d][n] && arready[d][n];
      if (ar_hs[d][n]) obs_grants[d].push_back(n);
      if (arready[d][n]) arrdy_seen[d][n]++;
      if (rvalid[d][n]) rv_seen[d][n]++;
      if (rvalid[d][n] && rready[d][n]) begin
        rx[d][n].push_back(rdata[d][n]);
        rxl[d][n].push_back(rlast[d][n]);
      end
    end
    if (beat_err[d]) err_cnt[d]++;
    if (s_arvalid[d] && s_arready[d]) begin
      pl = int'(s_arlen[d]) + 1;
      if ($urandom_range(0, 99) < p_err) pl = $urandom_range(1, int'(s_arlen[d]) + 3);
      bq[d].push_back(pl);
    end else if (bq[d].size() > 0 && s_rvalid[d] && s_rready[d]) begin
      if (s_rlast[d]) begin
        void'(bq[d].pop_front());
        bidx[d] = 0;
      end else begin
        bidx[d]++;
      end
    end
  endtask

  task automatic drive_agents(int d);
    for (int n = 0; n < 2; n++) begin
      if (ar_hs[d][n]) arvalid[d][n] = 1'b0;
      if (!arvalid[d][n] && $urandom_range(0, 99) < p_req) begin
        arvalid[d][n] = 1'b1;
        araddr[d][n]  = $urandom;
        arlen[d][n]   = 8'($urandom_range(0, 4));
        arburst[d][n] = 2'($urandom_range(0, 2));
      end
      rready[d][n] = ($urandom_range(0, 99) < p_rdy);
    end
    s_arready[d] = ($urandom_range(0, 99) < p_ar);
    s_rdata[d]   = $urandom;
    if (bq[d].size() > 0) begin
      s_rvalid[d] = ($urandom_range(0, 99) < p_rv);
      s_rlast[d]  = (bidx[d] == bq[d][0] - 1);
    end else begin
      s_rvalid[d] = ($urandom_range(0, 99) < 8);
      s_rlast[d]  = 1'($urandom_range(0, 1));
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      check(d);
      observe(d);
    end
    @(posedge clk);
    if (rst_n) for (int d = 0; d < 2; d++) model_step(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) if (auto_en[d]) drive_agents(d);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        araddr[d][n] = '0; arlen[d][n] = '0; arburst[d][n] = '0;
        arvalid[d][n] = 1'b0; rready[d][n] = 1'b0;
      end
      s_arready[d] = 1'b0; s_rdata[d] = '0; s_rvalid[d] = 1'b0; s_rlast[d] = 1'b0;
    end
  endtask

  task automatic clear_tb_state();
    for (int d = 0; d < 2; d++) begin
      auto_en[d] = 0;
      model_reset(d);
      obs_grants[d].delete();
      bq[d].delete();
      bidx[d] = 0;
      err_cnt[d] = 0;
      for (int n = 0; n < 2; n++) begin
        rx[d][n].delete(); rxl[d][n].delete();
        rv_seen[d][n] = 0; arrdy_seen[d][n] = 0; ar_hs[d][n] = 0;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    clear_tb_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    p_req = 0; p_rdy = 0; p_ar = 0; p_rv = 0; p_err = 0;

    // Single request on port 0 of the round-robin instance
    apply_reset();
    chk("reset busy", busy[0], 0);
    chk("reset s_arvalid", s_arvalid[0], 0);
    chk("reset beat_err", beat_err[0], 0);
    araddr[0][0] = 32'h1FC0_0000; arlen[0][0] = 8'd3; arburst[0][0] = 2'd2;
    arvalid[0][0] = 1'b1; rready[0][0] = 1'b1; rready[0][1] = 1'b1;
    tick();
    chk("single s_arvalid one cycle later", s_arvalid[0], 1);
    chk("single s_araddr", s_araddr[0], 32'h1FC0_0000);
    chk("single s_arlen", s_arlen[0], 3);
    chk("single s_arburst", s_arburst[0], 2);
    tick(); tick();
    s_arready[0] = 1'b1;
    tick();
    arvalid[0][0] = 1'b0; s_arready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid[0] = 1'b1; s_rdata[0] = 32'hA0 + i; s_rlast[0] = (i == 3);
      tick();
    end
    s_rvalid[0] = 1'b0; s_rlast[0] = 1'b0;
    tick();
    chk("single beat count", rx[0][0].size(), 4);
    if (rx[0][0].size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("single beat %0d data", i), rx[0][0][i], 32'hA0 + i);
        chk($sformatf("single beat %0d rlast", i), rxl[0][0][i], i == 3);
      end
    end
    chk("single m1_rvalid never", rv_seen[0][1], 0);
    chk("single busy after rlast", busy[0], 0);
    chk("single beat_err never", err_cnt[0], 0);

    // Continuous contention on both instances
    apply_reset();
    p_req = 100; p_rdy = 100; p_ar = 100; p_rv = 100; p_err = 0;
    auto_en[0] = 1; auto_en[1] = 1;
    drive_agents(0); drive_agents(1);
    for (int c = 0; c < 300 && !(obs_grants[0].size() >= 4 && obs_grants[1].size() >= 3); c++) tick();
    chk("rr grant count", obs_grants[0].size() >= 4, 1);
    chk("fp grant count", obs_grants[1].size() >= 3, 1);
    if (obs_grants[0].size() >= 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rr grant %0d", i), obs_grants[0][i], i % 2);
    if (obs_grants[1].size() >= 3)
      for (int i = 0; i < 3; i++) chk($sformatf("fp grant %0d", i), obs_grants[1][i], 1);
    chk("fp m0_arready never", arrdy_seen[1][0], 0);

    // Backpressure on port 1 of the fixed-priority instance
    apply_reset();
    araddr[1][1] = 32'h8000_0040; arlen[1][1] = 8'd1; arburst[1][1] = 2'd1;
    arvalid[1][1] = 1'b1; rready[1][1] = 1'b1;
    tick();
    s_arready[1] = 1'b1;
    tick();
    arvalid[1][1] = 1'b0; s_arready[1] = 1'b0;
    s_rvalid[1] = 1'b1; s_rdata[1] = 32'hB0; s_rlast[1] = 1'b0;
    tick();
    s_rdata[1] = 32'hB1; s_rlast[1] = 1'b1; rready[1][1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp s_rready low %0d", i), s_rready[1], 0);
      chk($sformatf("bp busy held %0d", i), busy[1], 1);
    end
    rready[1][1] = 1'b1;
    tick();
    s_rvalid[1] = 1'b0; s_rlast[1] = 1'b0;
    tick();
    chk("bp beats received", rx[1][1].size(), 2);
    if (rx[1][1].size() == 2) chk("bp held beat data", rx[1][1][1], 32'hB1);
    chk("bp no beat_err", err_cnt[1], 0);
    chk("bp idle after", busy[1], 0);

    // Early rlast: arlen=3 but rlast on beat 2
    apply_reset();
    araddr[0][0] = 32'h0000_2000; arlen[0][0] = 8'd3; arvalid[0][0] = 1'b1; rready[0][0] = 1'b1;
    tick();
    s_arready[0] = 1'b1;
    tick();
    arvalid[0][0] = 1'b0; s_arready[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_rvalid[0] = 1'b1; s_rdata[0] = 32'hC0 + i; s_rlast[0] = (i == 1);
      tick();
    end
    s_rvalid[0] = 1'b0; s_rlast[0] = 1'b0;
    tick(); tick();
    chk("lenerr beat_err cycles", err_cnt[0], 1);
    chk("lenerr back to idle", busy[0], 0);

    // Asynchronous reset in the middle of a burst
    apply_reset();
    araddr[0][1] = 32'h0000_3000; arlen[0][1] = 8'd3; arvalid[0][1] = 1'b1; rready[0][1] = 1'b1;
    tick();
    s_arready[0] = 1'b1;
    tick();
    arvalid[0][1] = 1'b0; s_arready[0] = 1'b0;
    s_rvalid[0] = 1'b1; s_rdata[0] = 32'hD0; s_rlast[0] = 1'b0;
    tick();
    s_rdata[0] = 32'hD1;
    #2;
    chk("midrst busy before", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy[0], 0);
    chk("midrst s_rready", s_rready[0], 0);
    chk("midrst m1_rvalid", rvalid[0][1], 0);
    chk("midrst m1_rdata", rdata[0][1], 0);
    chk("midrst s_arvalid", s_arvalid[0], 0);
    chk("midrst s_araddr", s_araddr[0], 0);
    chk("midrst s_arlen", s_arlen[0], 0);
    clear_inputs();
    clear_tb_state();
    @(negedge clk);
    rst_n = 1'b1;
    araddr[0][1] = 32'h0000_1000; arlen[0][1] = 8'd0; arvalid[0][1] = 1'b1; rready[0][1] = 1'b1;
    tick();
    chk("post-reset s_arvalid", s_arvalid[0], 1);
    chk("post-reset s_araddr", s_araddr[0], 32'h0000_1000);
    s_arready[0] = 1'b1;
    tick();
    arvalid[0][1] = 1'b0; s_arready[0] = 1'b0;
    chk("post-reset grant count", obs_grants[0].size(), 1);
    if (obs_grants[0].size() == 1) chk("post-reset grant port", obs_grants[0][0], 1);
    s_rvalid[0] = 1'b1; s_rdata[0] = 32'hE0; s_rlast[0] = 1'b1;
    tick();
    s_rvalid[0] = 1'b0; s_rlast[0] = 1'b0;
    tick();
    chk("post-reset beat data", rx[0][1].size() == 1 && rx[0][1][0] == 32'hE0, 1);
    chk("post-reset idle", busy[0], 0);

    // Randomized traffic on both instances against the model
    apply_reset();
    p_req = 40; p_rdy = 70; p_ar = 50; p_rv = 70; p_err = 15;
    auto_en[0] = 1; auto_en[1] = 1;
    drive_agents(0); drive_agents(1);
    repeat (3000) tick();
    chk("random rr made progress", obs_grants[0].size() > 20, 1);
    chk("random fp made progress", obs_grants[1].size() > 20, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
